// File: rtl/shared_reg_write_arbiter_pkg.sv
// Shared types and helpers for the shared-register write arbiter.
package shared_reg_write_arbiter_pkg;

    // Arbiter FSM: nobody owns the register, or one requester owns it.
    typedef enum logic {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } arb_state_e;

    // Index width that stays at least 1 bit for degenerate sizes.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module shared_reg_write_arbiter_rr_pick
    import shared_reg_write_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               any_o
);

    // Scan ptr+1, ptr+2, ... so the last owner has the lowest priority.
    always_comb begin
        logic             found;
        logic [IdxW-1:0]  cand;
        found  = 1'b0;
        cand   = '0;
        pick_o = '0;
        idx_o  = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = IdxW'((int'(ptr_i) + i) % int'(NUM_REQ));
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                idx_o        = cand;
                pick_o[cand] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/shared_reg_write_arbiter.sv
// Round-robin write arbiter in front of one shared enable-gated register.
// A grant lasts until the owner drops its request, flags last, or hits MAX_BURST;
// every release is followed by one idle cycle before the next grant.
module shared_reg_write_arbiter
    import shared_reg_write_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned WIDTH     = 32,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned IdxW      = idx_width(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       last_i,
    input  logic [NUM_REQ*WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [IdxW-1:0]          owner_o,
    output logic [WIDTH-1:0]         q_o,
    output logic                     wr_o,
    output logic                     busy_o
);

    localparam int unsigned CntW = idx_width(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               wr_q, wr_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IdxW-1:0]    pick_idx;
    logic               pick_any;
    logic [WIDTH-1:0]   slice [NUM_REQ];
    logic               own_req;
    logic               own_last;
    logic [CntW-1:0]    cnt_inc;

    for (genvar k = 0; k < int'(NUM_REQ); k++) begin : g_slice
        assign slice[k] = data_i[k*WIDTH +: WIDTH];
    end

    shared_reg_write_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .pick_o (pick_onehot),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign own_req  = req_i[owner_q];
    assign own_last = last_i[owner_q];
    assign cnt_inc  = cnt_q + CntW'(1);

    // Next-state: grant from idle, or write/release while owned.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        wr_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StOwn;
                    gnt_d   = pick_onehot;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            StOwn: begin
                if (own_req) begin
                    q_d   = slice[owner_q];
                    wr_d  = 1'b1;
                    cnt_d = cnt_inc;
                end
                // Dropped request, last flag, or full burst all collapse into one release.
                if (!own_req || own_last || (cnt_inc == MaxCnt)) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset drops any write in flight and parks the pointer at NUM_REQ-1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= IdxW'(NUM_REQ - 1);
            cnt_q   <= '0;
            q_q     <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            wr_q    <= wr_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign owner_o = owner_q;
    assign q_o     = q_q;
    assign wr_o    = wr_q;
    assign busy_o  = (state_q == StOwn);

endmodule
